// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the fetch PC and a single-outstanding
// instruction-memory handshake, presenting one instruction at a time to IF/ID.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | no request outstanding; request pc_reg next
// WAIT    | request outstanding, response will be presented
// HOLD    | instruction presented, waiting for decode
// DISCARD | request outstanding, its response is stale
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [31:0] pc_reg;
  logic [31:0] pc_reg_plus4;
  logic [31:0] redirect_tgt;

  assign pc_reg_plus4 = pc_reg + 32'd4;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (!redirect_en) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_en)      state_d = imem_rvalid ? S_IDLE : S_DISCARD;
        else if (imem_rvalid) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (redirect_en)  state_d = S_IDLE;
        else if (!StallD) state_d = S_WAIT;
      end
      S_DISCARD: begin
        // The stale response retires the outstanding request even if a new
        // redirect lands in the same cycle; pc_reg already holds the target.
        if (imem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_reg;
    if (!redirect_en) begin
      case (state)
        S_IDLE: imem_req = 1'b1;
        S_HOLD: begin
          if (!StallD) begin
            imem_req  = 1'b1;
            imem_addr = pc_reg_plus4;
          end
        end
        default: imem_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg      <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      pc          <= RESET_PC;
      pc_plus4    <= RESET_PC + 32'd4;
      proto_err   <= 1'b0;
    end else begin
      if (imem_rvalid && (state == S_IDLE || state == S_HOLD)) proto_err <= 1'b1;
      if (redirect_en) begin
        pc_reg      <= redirect_tgt;
        instr_valid <= 1'b0;
      end else begin
        case (state)
          S_WAIT: begin
            if (imem_rvalid) begin
              instr       <= imem_rdata;
              pc          <= pc_reg;
              pc_plus4    <= pc_reg_plus4;
              instr_valid <= 1'b1;
            end
          end
          S_HOLD: begin
            if (!StallD) begin
              pc_reg      <= pc_reg_plus4;
              instr_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural variable-latency
// instruction memory driven from the stimulus thread.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallD;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        proto_err;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .StallD     (StallD),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .proto_err  (proto_err)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  int          lat = 1;
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr_q = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8) return 32'h00A0_0093;
    return 32'h1300_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample the request before the edge, then advance the memory.
  task automatic tick();
    logic        req_s;
    logic [31:0] addr_s;
    #1;
    req_s  = imem_req && !reset;
    addr_s = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (req_s) begin
      mem_busy   = 1'b1;
      mem_cnt    = lat;
      mem_addr_q = addr_s;
    end
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr_q);
        mem_busy    = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; StallD = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    #1;
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_err", proto_err, 1'b0);

    // 1: back-to-back fetch with 1-cycle memory
    reset = 1'b0;
    #1;
    chk("t1_req0", imem_req, 1'b1);
    chk("t1_addr0", imem_addr, 32'h0);
    tick(); #1;
    chk("t1_wait_noreq", imem_req, 1'b0);
    tick(); #1;
    chk("t1_valid0", instr_valid, 1'b1);
    chk("t1_pc0", pc, 32'h0);
    chk("t1_pc4_0", pc_plus4, 32'h4);
    chk("t1_instr0", instr, 32'h1300_0000);
    chk("t1_req4", imem_req, 1'b1);
    chk("t1_addr4", imem_addr, 32'h4);
    tick(); #1;
    chk("t1_valid_drop", instr_valid, 1'b0);
    tick(); #1;
    chk("t1_pc4", pc, 32'h4);
    chk("t1_pc4_4", pc_plus4, 32'h8);
    chk("t1_addr8", imem_addr, 32'h8);
    tick(); tick(); #1;
    chk("t1_pc8", pc, 32'h8);
    chk("t1_instr8", instr, 32'h00A0_0093);

    // 2: decode stall holds the presented instruction
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_noreq", imem_req, 1'b0);
      chk("t2_valid", instr_valid, 1'b1);
      chk("t2_pc", pc, 32'h8);
      chk("t2_instr", instr, 32'h00A0_0093);
      tick();
    end
    StallD = 1'b0;
    lat = 3;
    #1;
    chk("t2_reqC", imem_req, 1'b1);
    chk("t2_addrC", imem_addr, 32'hC);
    tick();

    // 3: redirect while waiting on a 3-cycle response
    redirect_en = 1'b1; redirect_pc = 32'h103;
    #1;
    chk("t3_redir_noreq", imem_req, 1'b0);
    tick();
    redirect_en = 1'b0;
    #1;
    chk("t3_disc_valid", instr_valid, 1'b0);
    chk("t3_disc_noreq", imem_req, 1'b0);
    tick(); #1;
    chk("t3_stale_rvalid", imem_rvalid, 1'b1);
    chk("t3_stale_noreq", imem_req, 1'b0);
    tick(); #1;
    chk("t3_stale_dropped", instr_valid, 1'b0);
    chk("t3_req100", imem_req, 1'b1);
    chk("t3_addr100", imem_addr, 32'h100);
    tick(); tick(); tick(); #1;
    chk("t3_not_yet", instr_valid, 1'b0);
    tick(); #1;
    chk("t3_valid", instr_valid, 1'b1);
    chk("t3_pc", pc, 32'h100);
    chk("t3_instr", instr, 32'h1300_0100);

    // 4: redirect coinciding with a response
    lat = 1;
    #1;
    chk("t4_addr104", imem_addr, 32'h104);
    tick();
    redirect_en = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("t4_noreq", imem_req, 1'b0);
    tick();
    redirect_en = 1'b0;
    #1;
    chk("t4_valid", instr_valid, 1'b0);
    chk("t4_pc_kept", pc, 32'h100);
    chk("t4_req40", imem_req, 1'b1);
    chk("t4_addr40", imem_addr, 32'h40);
    tick(); tick(); #1;
    chk("t4_pc40", pc, 32'h40);
    chk("t4_valid40", instr_valid, 1'b1);

    // 5: redirect during a stalled HOLD
    StallD = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h200;
    #1;
    chk("t5_noreq", imem_req, 1'b0);
    tick();
    redirect_en = 1'b0; StallD = 1'b0;
    #1;
    chk("t5_valid", instr_valid, 1'b0);
    chk("t5_req200", imem_req, 1'b1);
    chk("t5_addr200", imem_addr, 32'h200);
    tick(); tick(); #1;
    chk("t5_pc200", pc, 32'h200);
    chk("t5_pc4", pc_plus4, 32'h204);

    // 6: spurious response in HOLD
    StallD = 1'b1;
    #1;
    chk("t6_err_clear", proto_err, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick(); #1;
    chk("t6_err_set", proto_err, 1'b1);
    chk("t6_instr", instr, 32'h1300_0200);
    chk("t6_pc", pc, 32'h200);
    tick(); tick(); #1;
    chk("t6_err_sticky", proto_err, 1'b1);
    StallD = 1'b0; reset = 1'b1;
    tick(); #1;
    chk("t6_rst_err", proto_err, 1'b0);
    chk("t6_rst_pc", pc, 32'h0);
    chk("t6_rst_valid", instr_valid, 1'b0);
    reset = 1'b0;
    #1;
    chk("t6_rst_addr", imem_addr, 32'h0);

    // PC wrap at the top of the address space
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_en = 1'b0;
    #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); tick(); #1;
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    chk("wrap_next", imem_addr, 32'h0);
    chk("wrap_err", proto_err, 1'b0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RV32I core; owns the fetch PC and the instruction-memory request/response handshake.
- Presents one fetched instruction at a time, with its PC and PC+4, to the IF/ID pipeline register.
- Honours the decode-stage stall from the hazard unit and execute-stage branch/jump redirects.
- Supports variable-latency instruction memory, with at most one outstanding request.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- StallD  input  1  decode stall; while high, the presented instruction is held.
- redirect_en  input  1  taken branch/jump from execute.
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.
- imem_req  output  1  single-cycle request strobe; always accepted by memory.
- imem_addr  output  32  request address; valid when imem_req=1.
- imem_rvalid  input  1  response strobe; arrives at least 1 cycle after imem_req.
- imem_rdata  input  32  instruction word; valid with imem_rvalid.
- instr_valid  output  1  instr, pc and pc_plus4 hold a live instruction.
- instr  output  32  fetched instruction.
- pc  output  32  address of instr.
- pc_plus4  output  32  pc+4, modulo 2^32.
- proto_err  output  1  sticky flag: response received with no request outstanding.

Behaviour:
- All outputs are registered except imem_req and imem_addr, which are combinational from state, pc_reg, StallD and redirect inputs.
- Reset, which has priority over all other inputs:
  - state=IDLE; pc_reg=RESET_PC.
  - instr_valid=0; instr=0; pc=RESET_PC; pc_plus4=RESET_PC+4; proto_err=0.
  - Reset mid-request makes the in-flight response unexpected. It is dropped and sets proto_err. The bench must drain memory or avoid this case.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - HOLD: instruction presented.
  - DISCARD: request outstanding, but its response is stale.
- IDLE, no redirect:
  - imem_req=1, imem_addr=pc_reg; next state WAIT.
- WAIT, imem_rvalid=1, no redirect:
  - instr<=imem_rdata; pc<=pc_reg; pc_plus4<=pc_reg+4; instr_valid<=1; next state HOLD.
- WAIT, imem_rvalid=0, no redirect: stay in WAIT.
- HOLD, StallD=1: all outputs hold; no request.
- HOLD, StallD=0 (instruction consumed this cycle):
  - pc_reg<=pc_reg+4; imem_req=1 with imem_addr=pc_reg+4 in the same cycle.
  - instr_valid<=0; next state WAIT.
- Throughput: one instruction per (memory latency + 1) cycles. Minimum is 2 cycles per instruction with 1-cycle memory.
- StallD is ignored when instr_valid=0.
- Redirect has priority over StallD and over a same-cycle response:
  - In every state: pc_reg<={redirect_pc[31:2],2'b00}; instr_valid<=0; no request is issued that cycle.
  - From IDLE or HOLD: next state IDLE. The next cycle requests the target.
  - From WAIT with imem_rvalid=0: next state DISCARD.
  - From WAIT with imem_rvalid=1: response dropped; next state IDLE.
  - From DISCARD: stay in DISCARD, with pc_reg updated to the new target.
- DISCARD:
  - On imem_rvalid: response dropped, no output change; next state IDLE.
  - Otherwise stay in DISCARD.
- imem_rvalid while in IDLE or HOLD: response ignored, outputs unchanged, proto_err<=1. proto_err stays set until reset.
- PC wrap: 32'hFFFF_FFFC+4 wraps to 0 with no error.
- Fetch never runs ahead of decode. When instr_valid is 1, no request is outstanding.

Test Plan:
1. Reset, 1-cycle memory, StallD=0:
   - imem_addr sequence 0x0,0x4,0x8 on cycles 1,3,5 after reset deassert.
   - instr_valid pulses with pc=0x0,0x4,0x8; pc_plus4=pc+4.
2. StallD=1 for 3 cycles while HOLD has pc=0x8, instr=0x00A00093:
   - Outputs frozen; imem_req=0 throughout.
   - Next request is 0xC in the cycle StallD falls.
3. Redirect to 0x103 during WAIT, 3-cycle memory:
   - Stale response dropped; instr_valid stays 0.
   - Next request addr=0x100; presented pc=0x100.
4. Redirect to 0x40 in the same cycle as imem_rvalid in WAIT:
   - Data not presented; next state IDLE.
   - Request 0x40 on the following cycle.
5. Redirect to 0x200 while HOLD with StallD=1:
   - instr_valid->0; no request that cycle.
   - Request 0x200 on the next cycle.
6. Spurious imem_rvalid in HOLD:
   - proto_err->1 and stays 1; presented instr unchanged.
   - Reset clears proto_err and sets pc_reg=RESET_PC.
